// File: rtl/segre_icache.sv
// Direct-mapped, read-only instruction cache with a zero-latency hit path and a
// line-wide refill FSM (IDLE -> REQ -> WAIT) against instruction memory.
module segre_icache #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_LINES  = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     fetch_valid_i,
    input  logic [ADDR_WIDTH-1:0]    fetch_addr_i,
    output logic                     hit_o,
    output logic [31:0]              instr_o,
    input  logic                     invalidate_i,
    output logic                     mem_rd_o,
    output logic [ADDR_WIDTH-1:0]    mem_addr_o,
    input  logic                     mem_ready_i,
    input  logic [32*LINE_WORDS-1:0] mem_data_i
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                          state_q;
    logic [NUM_LINES-1:0]            valid_q;
    logic [TAG_W-1:0]                tag_q  [NUM_LINES];
    logic [LINE_WORDS-1:0][31:0]     data_q [NUM_LINES];
    logic [ADDR_WIDTH-1:0]           miss_addr_q;
    logic                            mem_rd_q;
    logic                            flushed_q;

    logic [OFF_W-1:0]                f_off;
    logic [IDX_W-1:0]                f_idx;
    logic [TAG_W-1:0]                f_tag;
    logic [IDX_W-1:0]                miss_idx;
    logic [TAG_W-1:0]                miss_tag;
    logic [ADDR_WIDTH-1:0]           miss_line;
    logic                            hit;
    logic [31:0]                     instr;
    logic                            fill_en;
    logic                            unused_addr_bits;

    assign f_off     = fetch_addr_i[OFF_W+1:2];
    assign f_idx     = fetch_addr_i[OFF_W+IDX_W+1:OFF_W+2];
    assign f_tag     = fetch_addr_i[ADDR_WIDTH-1:ADDR_WIDTH-TAG_W];
    assign miss_idx  = miss_addr_q[OFF_W+IDX_W+1:OFF_W+2];
    assign miss_tag  = miss_addr_q[ADDR_WIDTH-1:ADDR_WIDTH-TAG_W];
    assign miss_line = {fetch_addr_i[ADDR_WIDTH-1:OFF_W+2], {(OFF_W+2){1'b0}}};
    assign unused_addr_bits = ^fetch_addr_i[1:0];

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        hit   = 1'b0;
        instr = NOP;
        if (fetch_valid_i && state_q == IDLE && valid_q[f_idx] && tag_q[f_idx] == f_tag) begin
            hit   = 1'b1;
            instr = data_q[f_idx][f_off];
        end
    end

    // Filling is only possible while a request is outstanding, so the hit path never races it.
    assign fill_en = (state_q != IDLE) && mem_ready_i;

    // NOTE: tag/data arrays carry no reset; only the valid bits decide whether they are used.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            data_q[miss_idx] <= mem_data_i;
            tag_q[miss_idx]  <= miss_tag;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            mem_rd_q    <= 1'b0;
            flushed_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (invalidate_i) begin
                        valid_q <= '0;
                    end else if (fetch_valid_i && !hit) begin
                        miss_addr_q <= miss_line;
                        mem_rd_q    <= 1'b1;
                        flushed_q   <= 1'b0;
                        state_q     <= REQ;
                    end
                end
                REQ, WAIT: begin
                    // A flush during refill must keep the incoming (possibly stale) line invalid.
                    if (invalidate_i) begin
                        valid_q   <= '0;
                        flushed_q <= 1'b1;
                    end
                    if (mem_ready_i) begin
                        if (!(flushed_q || invalidate_i)) begin
                            valid_q[miss_idx] <= 1'b1;
                        end
                        mem_rd_q <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hit_o      = hit;
    assign instr_o    = instr;
    assign mem_rd_o   = mem_rd_q;
    assign mem_addr_o = miss_addr_q;

endmodule

// File: tb/tb_segre_icache.sv
// Scoreboard bench for segre_icache: the driver predicts each cycle's outputs from
// a line-residency model and queues them; a negedge monitor pops and compares.
module tb_segre_icache;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         fetch_valid_i = 1'b0;
    logic [31:0]  fetch_addr_i = '0;
    logic         hit_o;
    logic [31:0]  instr_o;
    logic         invalidate_i = 1'b0;
    logic         mem_rd_o;
    logic [31:0]  mem_addr_o;
    logic         mem_ready_i = 1'b0;
    logic [127:0] mem_data_i = '0;

    segre_icache #(.ADDR_WIDTH(32), .NUM_LINES(8), .LINE_WORDS(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_addr_i  (fetch_addr_i),
        .hit_o         (hit_o),
        .instr_o       (instr_o),
        .invalidate_i  (invalidate_i),
        .mem_rd_o      (mem_rd_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ready_i   (mem_ready_i),
        .mem_data_i    (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          hit;
        logic [31:0] instr;
        bit          rd;
        bit          chk_addr;
        logic [31:0] maddr;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: which memory line each index holds, and whether it is valid.
    logic [31:0] res_line [8];
    bit          res_valid[8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [127:0] line_data(input logic [31:0] base);
        logic [127:0] d;
        for (int w = 0; w < 4; w++) d[w*32 +: 32] = mem_word(base + 32'(4 * w));
        return d;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int idx;
        idx = int'((a >> 4) & 32'd7);
        return res_valid[idx] && res_line[idx] == (a >> 4);
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < 8; i++) res_valid[i] = 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit fv, input bit inv, input bit rdy,
                        input logic [31:0] addr, input logic [127:0] data,
                        input bit e_hit, input logic [31:0] e_instr,
                        input bit e_rd, input bit chk_addr, input logic [31:0] e_maddr);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i         = r;
        fetch_valid_i = fv;
        fetch_addr_i  = addr;
        invalidate_i  = inv;
        mem_ready_i   = rdy;
        mem_data_i    = data;
        e.hit = e_hit; e.instr = e_instr; e.rd = e_rd; e.chk_addr = chk_addr; e.maddr = e_maddr;
        exp_q.push_back(e);
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_cycle();
        step(0, 0, 0, 0, $urandom, '0, 0, NOP, 0, 0, 0);
    endtask

    // Fetch until the line is served; inv_at selects a refill cycle that also flushes.
    task automatic do_fetch(input logic [31:0] addr, input int lat, input int inv_at, input bit toggle);
        int          inv_k;
        bit          flushed;
        logic [31:0] line;
        inv_k = inv_at;
        for (int tries = 0; tries < 3; tries++) begin
            if (model_hit(addr)) begin
                step(0, 1, 0, 0, addr, '0, 1, mem_word(addr & ~32'h3), 0, 0, 0);
                return;
            end
            line = addr & ~32'hF;
            step(0, 1, 0, 0, addr, '0, 0, NOP, 0, 0, 0);
            flushed = 1'b0;
            for (int k = 0; k <= lat; k++) begin
                bit rdy, inv, fv2;
                logic [31:0] a2;
                rdy = (k == lat);
                inv = (k == inv_k);
                if (inv) begin
                    flushed = 1'b1;
                    model_flush();
                end
                a2  = toggle ? $urandom : addr;
                fv2 = toggle ? 1'($urandom) : 1'b1;
                step(0, fv2, inv, rdy, a2, rdy ? line_data(line) : rand_line(), 0, NOP, 1, 1, line);
            end
            if (!flushed) begin
                res_line[int'((line >> 4) & 32'd7)]  = line >> 4;
                res_valid[int'((line >> 4) & 32'd7)] = 1'b1;
            end
            inv_k = -1;
        end
        $display("FAIL fetch_loop at %0t: addr %h never served by model", $time, addr);
        miscompares++;
    endtask

    task automatic do_inv(input logic [31:0] addr, input bit fv);
        bit h;
        h = fv && model_hit(addr);
        step(0, fv, 1, 0, addr, '0, h, h ? mem_word(addr & ~32'h3) : NOP, 0, 0, 0);
        model_flush();
    endtask

    // Monitor: compare DUT outputs against the queued expectation for every driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("hit_o", 32'(hit_o), 32'(e.hit));
                check("instr_o", instr_o, e.instr);
                check("mem_rd_o", 32'(mem_rd_o), 32'(e.rd));
                if (e.chk_addr) check("mem_addr_o", mem_addr_o, e.maddr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog at %0t: simulation did not finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_flush();
        for (int i = 0; i < 8; i++) res_line[i] = '0;

        // Reset state, even with a fetch presented.
        step(1, 1, 0, 0, 32'h100, '0, 0, NOP, 0, 1, 0);
        step(1, 1, 0, 0, 32'h100, '0, 0, NOP, 0, 1, 0);
        idle_cycle();

        // Cold miss with immediate ready, then the rest of the line hits.
        do_fetch(32'h100, 0, -1, 0);
        do_fetch(32'h104, 0, -1, 0);
        do_fetch(32'h108, 0, -1, 0);
        do_fetch(32'h10C, 0, -1, 0);

        // Slow memory with the fetch address wandering during the refill.
        do_fetch(32'h200, 3, -1, 1);
        do_fetch(32'h20C, 0, -1, 0);

        // Same index, different tag evicts.
        do_fetch(32'h000, 0, -1, 0);
        do_fetch(32'h080, 1, -1, 0);
        do_fetch(32'h000, 0, -1, 0);

        // Fill every line, flush in IDLE, then everything misses again.
        for (int i = 0; i < 8; i++) do_fetch(32'h400 + 32'(16 * i), 0, -1, 0);
        do_inv(32'h400, 1);
        for (int i = 0; i < 8; i++) do_fetch(32'h404 + 32'(16 * i), 0, -1, 0);

        // Flush while waiting on memory: fill completes but the line stays invalid.
        do_fetch(32'h300, 2, 1, 0);

        // Reset pulse while waiting on memory; a late ready must not fill.
        model_flush();
        do_inv(32'h240, 0);
        step(0, 1, 0, 0, 32'h240, '0, 0, NOP, 0, 0, 0);
        step(0, 1, 0, 0, 32'h240, rand_line(), 0, NOP, 1, 1, 32'h240);
        step(1, 1, 0, 0, 32'h240, rand_line(), 0, NOP, 0, 1, 0);
        model_flush();
        step(0, 0, 0, 1, 32'h240, line_data(32'h240), 0, NOP, 0, 1, 0);
        do_fetch(32'h240, 0, -1, 0);

        // Randomized traffic over a small address window to force conflicts.
        for (int n = 0; n < 300; n++) begin
            int          sel, lat;
            logic [31:0] a;
            sel = int'($urandom_range(0, 9));
            lat = int'($urandom_range(0, 3));
            a   = 32'($urandom_range(0, 1023));
            case (sel)
                0:       do_inv(a, 1'($urandom));
                1:       idle_cycle();
                2:       do_fetch(a, lat, int'($urandom_range(0, lat)), 1'($urandom));
                default: do_fetch(a, lat, -1, 1'($urandom));
            endcase
        end

        idle_cycle();
        idle_cycle();
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/segre_icache.md
# segre_icache

Direct-mapped, read-only instruction cache between the IF stage and instruction memory. It answers each fetch combinationally with a hit indication (`ic_if_hit`) and the selected instruction word. On a miss it runs a refill FSM against a line-wide memory read port. The pipeline controller holds IF and bubbles ID while hit is low.

## Interface
Parameters:
- ADDR_WIDTH, 32, fetch/memory address width in bits
- NUM_LINES, 8, number of cache lines; power of two, ≥2
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2
- Derived:
  - LINE_BITS = 32*LINE_WORDS
  - OFF_W = log2(LINE_WORDS)
  - IDX_W = log2(NUM_LINES)
  - TAG_W = ADDR_WIDTH-2-OFF_W-IDX_W

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset, asynchronous, active-high
- fetch_valid_i  in  1  IF presents a valid fetch address this cycle
- fetch_addr_i  in  ADDR_WIDTH  fetch address; bits [1:0] ignored
- hit_o  out  1  instruction available this cycle (to controller `ic_if_hit`)
- instr_o  out  32  fetched instruction; 32'h00000013 (NOP) when hit_o=0
- invalidate_i  in  1  clear all valid bits (fence.i / flush)
- mem_rd_o  out  1  line read request to memory
- mem_addr_o  out  ADDR_WIDTH  line-aligned request address (low OFF_W+2 bits zero)
- mem_ready_i  in  1  memory returns a line this cycle
- mem_data_i  in  LINE_BITS  returned line; word 0 in bits [31:0]

## Operation
- Address split:
  - word offset = addr[OFF_W+1:2]
  - index = addr[OFF_W+IDX_W+1:OFF_W+2]
  - tag = remaining upper bits
- Storage:
  - valid bit, tag and data per line, held in flops.
  - Valid bits are reset; tag and data arrays are not.
- Lookup (combinational):
  - hit_o = fetch_valid_i & state==IDLE & valid[idx] & tag[idx]==tag.
  - instr_o = data[idx] word[offset] when hit_o, else NOP.
- FSM states: IDLE, REQ, WAIT.
  - IDLE:
    - If fetch_valid_i and not hit and not invalidate_i: latch the line address into miss_addr and go to REQ.
    - Otherwise stay in IDLE.
  - REQ:
    - mem_rd_o=1, mem_addr_o=miss_addr.
    - If mem_ready_i: fill the line and go to IDLE. Otherwise go to WAIT.
  - WAIT:
    - mem_rd_o held at 1 and mem_addr_o held stable until mem_ready_i.
    - On mem_ready_i: fill the line and go to IDLE.
- Fill:
  - data[miss_idx] <= mem_data_i
  - tag[miss_idx] <= miss_tag
  - valid[miss_idx] <= 1
- Request/ready handshake: mem_rd_o stays high from REQ entry through the mem_ready_i cycle, and drops the following cycle. mem_ready_i is ignored when mem_rd_o=0.
- The refill always uses the latched miss_addr. fetch_addr_i changes during the miss do not affect the request. After returning to IDLE the current fetch_addr_i is looked up again.
- invalidate_i:
  - In IDLE: all valid bits clear next edge, and no miss starts that cycle.
  - In REQ/WAIT: all valid bits clear, but the request is still held until mem_ready_i. That fill writes data and tag but leaves valid=0, so a stale line is never made valid after a flush.
- Fill and lookup on the same index never conflict, because hit_o=0 outside IDLE.

## Timing
- Reset (asynchronous assert): state=IDLE, all valid=0, miss_addr=0, mem_rd_o=0, mem_addr_o=0, hit_o=0, instr_o=NOP.
- Reset deasserting mid-refill: the refill is abandoned. Any late mem_ready_i is ignored.
- Hit latency: 0 cycles (same cycle as fetch_valid_i).
- Miss, memory ready immediately:
  - Cycle N: miss.
  - Cycle N+1: REQ, with mem_ready_i.
  - Cycle N+2: IDLE, hit_o=1. Minimum penalty is 2 cycles.
- Miss with memory latency L (ready L cycles after mem_rd_o rises): hit at N+2+L.
- Back-to-back misses to different lines: the second REQ starts 1 cycle after the first fill, earliest at N+3.
- Capacity conflict: an address with the same index but a different tag evicts the line unconditionally on refill.

## Test plan
- After reset, fetch 0x100:
  - Cycle 0: hit_o=0.
  - Cycle 1: mem_rd_o=1, mem_addr_o=0x100.
  - With ready at cycle 1 returning words {A,B,C,D}: cycle 2 gives hit_o=1, instr_o=A.
  - Then 0x104/0x108/0x10C hit with B/C/D, with no new request.
- Memory ready delayed 3 cycles:
  - mem_rd_o and mem_addr_o stay stable through the ready cycle.
  - fetch_addr_i toggled meanwhile does not change mem_addr_o.
  - hit occurs at N+5.
- Conflict with NUM_LINES=8, LINE_WORDS=4: fill 0x000, then fetch 0x080 (same index) → miss and refill. Fetching 0x000 again → miss.
- invalidate_i in IDLE with all 8 lines valid: every subsequent fetch misses. No mem_rd_o in the invalidate cycle.
- invalidate_i asserted during WAIT:
  - The fill completes and mem_rd_o drops.
  - A re-fetch of the same address misses and issues a new request.
- rst_i pulsed during WAIT:
  - mem_rd_o=0 and hit_o=0 immediately (asynchronous).
  - A subsequent mem_ready_i produces no fill.
  - The next fetch misses.
